// File: rtl/front_pipe_pkg.sv
// Shared definitions for the fetch-side pipeline register bank.
package front_pipe_pkg;

  // addi x0, x0, 0: the instruction a squashed Decode slot presents.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Execute-stage control bundle, carried through ID/EX as one field.
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ctrl_e_t;

  // Bubble controls: nothing is written and no branch/jump is taken.
  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset and clear both load
// CLR_VALUE (clear beats enable); otherwise loads d while en is high.
module pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: rst/clr to the clear value, else hold or load.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= CLR_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/front_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the five-stage RV32I core.
// Optional macro PIPE_PERF_EN adds saturating StallCount/FlushCount.
module front_pipe_regs
  import front_pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     FlushE,
  input  logic                     PCSrcE,
  input  logic [DATA_WIDTH-1:0]    PCTargetE,
  input  logic [DATA_WIDTH-1:0]    InstrF,
  input  logic                     RegWriteD,
  input  logic                     MemWriteD,
  input  logic                     JumpD,
  input  logic                     BranchD,
  input  logic                     ALUSrcD,
  input  logic [1:0]               ResultSrcD,
  input  logic [2:0]               ALUControlD,
  input  logic [DATA_WIDTH-1:0]    RD1D,
  input  logic [DATA_WIDTH-1:0]    RD2D,
  input  logic [DATA_WIDTH-1:0]    ImmExtD,
  input  logic [ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [ADDRESS_WIDTH-1:0] RdD,
  output logic [DATA_WIDTH-1:0]    PCF,
  output logic [DATA_WIDTH-1:0]    PCPlus4F,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [DATA_WIDTH-1:0]    PCD,
  output logic [DATA_WIDTH-1:0]    PCPlus4D,
  output logic                     ValidD,
  output logic                     ValidE,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic                     JumpE,
  output logic                     BranchE,
  output logic                     ALUSrcE,
  output logic [1:0]               ResultSrcE,
  output logic [2:0]               ALUControlE,
  output logic [DATA_WIDTH-1:0]    RD1E,
  output logic [DATA_WIDTH-1:0]    RD2E,
  output logic [DATA_WIDTH-1:0]    ImmExtE,
  output logic [DATA_WIDTH-1:0]    PCE,
  output logic [DATA_WIDTH-1:0]    PCPlus4E,
  output logic [ADDRESS_WIDTH-1:0] Rs1E,
  output logic [ADDRESS_WIDTH-1:0] Rs2E,
  output logic [ADDRESS_WIDTH-1:0] RdE
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]              StallCount,
  output logic [31:0]              FlushCount
`endif
);

  // ---------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  pc_en;

  // Next PC: a redirect wins over a fetch stall.
  always_comb begin
    pc_next = PCSrcE ? PCTargetE : PCPlus4F;
    pc_en   = PCSrcE | ~StallF;
  end

  pipe_reg #(
    .WIDTH     (DATA_WIDTH),
    .CLR_VALUE (RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .clr (1'b0),
    .d   (pc_next),
    .q   (PCF)
  );

  // Sequential fetch address, wrapping modulo 2^DATA_WIDTH.
  always_comb begin
    PCPlus4F = PCF + DATA_WIDTH'(4);
  end

  // ---------------------------------------------------------------
  // IF/ID register: {InstrD, PCD, PCPlus4D, ValidD}
  // ---------------------------------------------------------------
  localparam int unsigned           IFID_W      = 3 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] NOP_D       = DATA_WIDTH'(NOP_INSTR);
  localparam logic [IFID_W-1:0]     IFID_BUBBLE = {NOP_D, {(2 * DATA_WIDTH){1'b0}}, 1'b0};

  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;

  // Fetch-stage bundle entering Decode; always a real instruction.
  always_comb begin
    ifid_d = {InstrF, PCF, PCPlus4F, 1'b1};
  end

  pipe_reg #(
    .WIDTH     (IFID_W),
    .CLR_VALUE (IFID_BUBBLE)
  ) u_ifid (
    .clk (clk),
    .rst (rst),
    .en  (~StallD),
    .clr (FlushD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  // Unpack the Decode-stage fields.
  always_comb begin
    {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;
  end

  // ---------------------------------------------------------------
  // ID/EX register: controls, operands, PCs, indices, valid
  // ---------------------------------------------------------------
  localparam int unsigned CTRL_W = $bits(ctrl_e_t);
  localparam int unsigned IDEX_W = CTRL_W + 5 * DATA_WIDTH + 3 * ADDRESS_WIDTH + 1;
  localparam logic [IDEX_W-1:0] IDEX_BUBBLE = {CTRL_BUBBLE, {(IDEX_W - CTRL_W){1'b0}}};

  ctrl_e_t           ctrl_d;
  ctrl_e_t           ctrl_e;
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;

  // Decode-stage bundle entering Execute; validity follows Decode.
  always_comb begin
    ctrl_d.RegWrite   = RegWriteD;
    ctrl_d.ResultSrc  = ResultSrcD;
    ctrl_d.MemWrite   = MemWriteD;
    ctrl_d.Jump       = JumpD;
    ctrl_d.Branch     = BranchD;
    ctrl_d.ALUControl = ALUControlD;
    ctrl_d.ALUSrc     = ALUSrcD;
    idex_d = {ctrl_d, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD};
  end

  // No stall input: Execute either loads or takes a bubble every cycle.
  pipe_reg #(
    .WIDTH     (IDEX_W),
    .CLR_VALUE (IDEX_BUBBLE)
  ) u_idex (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (FlushE),
    .d   (idex_d),
    .q   (idex_q)
  );

  // Unpack the Execute-stage fields; bubble indices are zero so they
  // never match a forwarding or load-use compare.
  always_comb begin
    {ctrl_e, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = idex_q;
    RegWriteE   = ctrl_e.RegWrite;
    ResultSrcE  = ctrl_e.ResultSrc;
    MemWriteE   = ctrl_e.MemWrite;
    JumpE       = ctrl_e.Jump;
    BranchE     = ctrl_e.Branch;
    ALUControlE = ctrl_e.ALUControl;
    ALUSrcE     = ctrl_e.ALUSrc;
  end

`ifdef PIPE_PERF_EN
  // ---------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------

  // Decode stalls and taken-redirect flushes, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != '1)) begin
        StallCount <= StallCount + 32'd1;
      end
      if (FlushE && PCSrcE && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_front_pipe_regs.sv
// Self-checking bench for front_pipe_regs: directed scenarios followed
// by randomized controls, checked against a cycle-level reference model.
module tb_front_pipe_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic        ValidD, ValidE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef PIPE_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  // Instruction memory: word n holds 32'hA + n.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA + (pc >> 2);
  endfunction

  always_comb InstrF = instr_of(PCF);

  front_pipe_regs #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (5),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk (clk), .rst (rst),
    .StallF (StallF), .StallD (StallD), .FlushD (FlushD), .FlushE (FlushE),
    .PCSrcE (PCSrcE), .PCTargetE (PCTargetE), .InstrF (InstrF),
    .RegWriteD (RegWriteD), .MemWriteD (MemWriteD), .JumpD (JumpD),
    .BranchD (BranchD), .ALUSrcD (ALUSrcD), .ResultSrcD (ResultSrcD),
    .ALUControlD (ALUControlD), .RD1D (RD1D), .RD2D (RD2D), .ImmExtD (ImmExtD),
    .Rs1D (Rs1D), .Rs2D (Rs2D), .RdD (RdD),
    .PCF (PCF), .PCPlus4F (PCPlus4F), .InstrD (InstrD), .PCD (PCD),
    .PCPlus4D (PCPlus4D), .ValidD (ValidD), .ValidE (ValidE),
    .RegWriteE (RegWriteE), .MemWriteE (MemWriteE), .JumpE (JumpE),
    .BranchE (BranchE), .ALUSrcE (ALUSrcE), .ResultSrcE (ResultSrcE),
    .ALUControlE (ALUControlE), .RD1E (RD1E), .RD2E (RD2E), .ImmExtE (ImmExtE),
    .PCE (PCE), .PCPlus4E (PCPlus4E), .Rs1E (Rs1E), .Rs2E (Rs2E), .RdE (RdE)
`ifdef PIPE_PERF_EN
    , .StallCount (StallCount), .FlushCount (FlushCount)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        rw, mw, j, b, as, v;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } estage_t;

  logic [31:0] m_pc;
  logic [31:0] m_instrD, m_pcD, m_pc4D;
  logic        m_validD;
  estage_t     m_e;
  logic [31:0] m_stalls, m_flushes;

  function automatic estage_t e_bubble();
    estage_t e;
    e.rw = 0; e.mw = 0; e.j = 0; e.b = 0; e.as = 0; e.v = 0;
    e.rs = 0; e.alu = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.pc4 = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0;
    return e;
  endfunction

  // One rising edge of the pipeline, computed from the old state.
  task automatic model_edge();
    logic [31:0] old_pc, old_pcD, old_pc4D;
    logic        old_validD;
    old_pc = m_pc; old_pcD = m_pcD; old_pc4D = m_pc4D; old_validD = m_validD;
    if (rst) begin
      m_pc = 32'h0;
      m_instrD = 32'h13; m_pcD = 0; m_pc4D = 0; m_validD = 0;
      m_e = e_bubble();
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (PCSrcE)       m_pc = PCTargetE;
      else if (!StallF) m_pc = old_pc + 32'd4;
      if (FlushD) begin
        m_instrD = 32'h13; m_pcD = 0; m_pc4D = 0; m_validD = 0;
      end else if (!StallD) begin
        m_instrD = instr_of(old_pc); m_pcD = old_pc; m_pc4D = old_pc + 32'd4; m_validD = 1;
      end
      if (FlushE) m_e = e_bubble();
      else begin
        m_e.rw = RegWriteD; m_e.mw = MemWriteD; m_e.j = JumpD; m_e.b = BranchD;
        m_e.as = ALUSrcD; m_e.rs = ResultSrcD; m_e.alu = ALUControlD;
        m_e.rd1 = RD1D; m_e.rd2 = RD2D; m_e.imm = ImmExtD;
        m_e.pc = old_pcD; m_e.pc4 = old_pc4D;
        m_e.rs1 = Rs1D; m_e.rs2 = Rs2D; m_e.rd = RdD; m_e.v = old_validD;
      end
      if (StallD && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (FlushE && PCSrcE && m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PCF", PCF, m_pc);
    chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    chk("InstrD", InstrD, m_instrD);
    chk("PCD", PCD, m_pcD);
    chk("PCPlus4D", PCPlus4D, m_pc4D);
    chk("ValidD", 32'(ValidD), 32'(m_validD));
    chk("ValidE", 32'(ValidE), 32'(m_e.v));
    chk("RegWriteE", 32'(RegWriteE), 32'(m_e.rw));
    chk("MemWriteE", 32'(MemWriteE), 32'(m_e.mw));
    chk("JumpE", 32'(JumpE), 32'(m_e.j));
    chk("BranchE", 32'(BranchE), 32'(m_e.b));
    chk("ALUSrcE", 32'(ALUSrcE), 32'(m_e.as));
    chk("ResultSrcE", 32'(ResultSrcE), 32'(m_e.rs));
    chk("ALUControlE", 32'(ALUControlE), 32'(m_e.alu));
    chk("RD1E", RD1E, m_e.rd1);
    chk("RD2E", RD2E, m_e.rd2);
    chk("ImmExtE", ImmExtE, m_e.imm);
    chk("PCE", PCE, m_e.pc);
    chk("PCPlus4E", PCPlus4E, m_e.pc4);
    chk("Rs1E", 32'(Rs1E), 32'(m_e.rs1));
    chk("Rs2E", 32'(Rs2E), 32'(m_e.rs2));
    chk("RdE", 32'(RdE), 32'(m_e.rd));
`ifdef PIPE_PERF_EN
    chk("StallCount", StallCount, m_stalls);
    chk("FlushCount", FlushCount, m_flushes);
`endif
  endtask

  // Inputs only change #1 after an edge, so the model sees the values
  // the DUT sampled.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_decode();
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
    BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic clear_ctl();
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; PCSrcE = 0; PCTargetE = 0;
  endtask

  task automatic load_use();
    StallF = 1; StallD = 1; FlushE = 1; rand_decode(); step();
    clear_ctl(); rand_decode(); step();
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    PCSrcE = 1; PCTargetE = tgt; FlushD = 1; FlushE = 1; rand_decode(); step();
    clear_ctl();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_pc = 0; m_instrD = 0; m_pcD = 0; m_pc4D = 0; m_validD = 0;
    m_e = e_bubble(); m_stalls = 0; m_flushes = 0;
    clear_ctl(); rand_decode();

    // Reset two cycles, then release.
    rst = 1; step(); step();
    rst = 0; #1;
    chk("rst_PCF", PCF, 32'h0);
    chk("rst_InstrD", InstrD, 32'h13);
    chk("rst_ValidD", 32'(ValidD), 32'h0);
    chk("rst_ValidE", 32'(ValidE), 32'h0);
    chk("rst_RdE", 32'(RdE), 32'h0);

    // Straight-line fetch.
    rand_decode(); step();
    chk("seq_PCF4", PCF, 32'h4);
    chk("seq_InstrD_A", InstrD, 32'hA);
    rand_decode(); step();
    chk("seq_PCF8", PCF, 32'h8);
    chk("seq_InstrD_B", InstrD, 32'hB);
    chk("seq_PCD", PCD, PCF - 32'd4);

    // Load-use at PCF = 8.
    StallF = 1; StallD = 1; FlushE = 1; rand_decode(); step();
    chk("lu_PCF_hold", PCF, 32'h8);
    chk("lu_InstrD_hold", InstrD, 32'hB);
    chk("lu_ValidE", 32'(ValidE), 32'h0);
    chk("lu_RdE", 32'(RdE), 32'h0);
    chk("lu_RD1E", RD1E, 32'h0);
    clear_ctl(); rand_decode(); step();
    chk("lu_PCE", PCE, 32'h4);
    chk("lu_ValidE_after", 32'(ValidE), 32'h1);
    chk("lu_PCF12", PCF, 32'hC);

    // Taken branch to 0x40.
    branch_to(32'h40);
    chk("br_PCF", PCF, 32'h40);
    chk("br_InstrD", InstrD, 32'h13);
    chk("br_ValidD", 32'(ValidD), 32'h0);
    chk("br_ValidE", 32'(ValidE), 32'h0);
    rand_decode(); step();
    chk("br_PCF_next", PCF, 32'h44);

    // Redirect to the top of the address space and wrap.
    branch_to(32'hFFFF_FFFC);
    chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
    rand_decode(); step();
    chk("wrap_PCF_next", PCF, 32'h0);

    // Redirect together with a fetch stall: redirect wins.
    StallF = 1; PCSrcE = 1; PCTargetE = 32'h100; step();
    chk("redir_over_stall", PCF, 32'h100);
    clear_ctl();

    // Reset in the middle of a stall/flush.
    StallF = 1; StallD = 1; FlushD = 1; FlushE = 1; PCSrcE = 1; PCTargetE = 32'h80;
    rst = 1; step();
    chk("rst_mid_PCF", PCF, 32'h0);
    rst = 0; clear_ctl(); step();
    chk("rst_first_fetch", PCD, 32'h0);

`ifdef PIPE_PERF_EN
    rst = 1; step(); rst = 0;
    for (int unsigned i = 0; i < 3; i++) load_use();
    for (int unsigned i = 0; i < 2; i++) begin
      branch_to(32'h200 + 32'(i) * 32'h10);
      step();
    end
    chk("perf_StallCount", StallCount, 32'd3);
    chk("perf_FlushCount", FlushCount, 32'd2);
    rst = 1; step();
    chk("perf_rst_Stall", StallCount, 32'd0);
    chk("perf_rst_Flush", FlushCount, 32'd0);
    chk("perf_rst_PCF", PCF, 32'h0);
    rst = 0;
`endif

    // Randomized controls, including occasional reset.
    for (int unsigned i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = ($urandom_range(0, 3) == 0);
      FlushD    = ($urandom_range(0, 4) == 0);
      FlushE    = ($urandom_range(0, 3) == 0);
      PCSrcE    = ($urandom_range(0, 5) == 0);
      PCTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      rand_decode();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
